// File: rtl/nn_fixed_pkg.sv
// nn_fixed_pkg: fixed-point widths, requantisation constants and sequencer
// states shared by the layer sequencers.
package nn_fixed_pkg;
  localparam int ACC_W = 23;
  localparam int PROD_W = 16;
  localparam int BIAS_W = 16;
  localparam int FRAC_SHIFT = 6;
  localparam logic [7:0] SAT_MAX = 8'd127;
  typedef enum logic [1:0] {IDLE, FETCH, MAC, OUT} state_e;
endpackage

// File: rtl/nn_requant.sv
// nn_requant: accumulator to 8-bit activation (ReLU, saturate, round-half-up).
// The 127+round case wraps to 8'h80 on purpose to match the reference model.
module nn_requant
  import nn_fixed_pkg::*;
(
  input  logic [ACC_W-1:0] acc_i,
  output logic [7:0]       q_o
);
  always_comb
    q_o = acc_i[ACC_W-1] ? 8'd0
        : (|acc_i[ACC_W-2:FRAC_SHIFT+7]) ? SAT_MAX
        : acc_i[FRAC_SHIFT+7:FRAC_SHIFT] + {7'd0, acc_i[FRAC_SHIFT-1]};
endmodule

// File: rtl/layer_mac_sequencer.sv
// layer_mac_sequencer: one fully connected layer evaluated node by node on a
// single 8x8 MAC, streaming requantised results over valid/ready.
module layer_mac_sequencer
  import nn_fixed_pkg::*;
#(
  parameter int INPUTS  = 30,
  parameter int NODES   = 16,
  parameter int IDX_W   = 5,
  parameter int NODE_W  = 4,
  parameter int WADDR_W = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               act_wr_en,
  input  logic [IDX_W-1:0]   act_wr_addr,
  input  logic [7:0]         act_wr_data,
  input  logic               start,
  output logic               busy,
  output logic               w_rd_en,
  output logic [WADDR_W-1:0] w_addr,
  input  logic [7:0]         w_data,
  output logic               b_rd_en,
  output logic [NODE_W-1:0]  b_addr,
  input  logic [15:0]        b_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NODE_W-1:0]  out_node,
  output logic [7:0]         out_data,
  output logic               done
);
  state_e state_q, state_d;
  logic [NODE_W-1:0] node_q, node_d, out_node_q, out_node_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WADDR_W-1:0] base_q, base_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [7:0] out_data_q, out_data_d, rq;
  logic done_q, done_d;
  logic signed [7:0] act_q [INPUTS];
  logic signed [PROD_W-1:0] prod;
  logic last_idx, last_node;

  assign last_idx  = idx_q == IDX_W'(INPUTS - 1);
  assign last_node = node_q == NODE_W'(NODES - 1);
  assign prod      = act_q[idx_q] * $signed(w_data);
  // The bias arrives with the first weight, so it seeds the sum at idx 0.
  assign acc_sum   = (idx_q == '0 ? {{(ACC_W-BIAS_W){b_data[BIAS_W-1]}}, b_data} : acc_q)
                   + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  nn_requant u_requant (.acc_i(acc_sum), .q_o(rq));

  assign busy      = state_q != IDLE;
  assign out_valid = state_q == OUT;
  assign out_node  = out_node_q;
  assign out_data  = out_data_q;
  assign done      = done_q;

  always_comb begin
    state_d    = state_q;
    node_d     = node_q;
    idx_d      = idx_q;
    base_d     = base_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_node_d = out_node_q;
    done_d     = 1'b0;
    w_rd_en    = 1'b0;
    w_addr     = '0;
    b_rd_en    = 1'b0;
    b_addr     = '0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        node_d  = '0;
        base_d  = '0;
      end
      FETCH: begin
        b_rd_en = 1'b1;
        b_addr  = node_q;
        w_rd_en = 1'b1;
        w_addr  = base_q;
        idx_d   = '0;
        state_d = MAC;
      end
      MAC: begin
        acc_d = acc_sum;
        if (!last_idx) begin
          w_rd_en = 1'b1;
          w_addr  = base_q + WADDR_W'(idx_q) + WADDR_W'(1);
          idx_d   = idx_q + 1'b1;
        end else begin
          state_d    = OUT;
          out_data_d = rq;
          out_node_d = node_q;
        end
      end
      OUT: if (out_ready) begin
        if (last_node) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = FETCH;
          node_d  = node_q + 1'b1;
          base_d  = base_q + WADDR_W'(INPUTS);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      node_q     <= '0;
      idx_q      <= '0;
      base_q     <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_node_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      node_q     <= node_d;
      idx_q      <= idx_d;
      base_q     <= base_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_node_q <= out_node_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < INPUTS; i++) act_q[i] <= '0;
    end else if (act_wr_en && !busy && 32'(act_wr_addr) < INPUTS) begin
      act_q[act_wr_addr] <= act_wr_data;
    end
  end
endmodule

// File: tb/tb_layer_mac_sequencer.sv
// tb_layer_mac_sequencer: directed vectors on a 4-input, 2-node layer with
// synchronous weight/bias ROM models.
module tb_layer_mac_sequencer;
  localparam int INPUTS = 4;
  localparam int NODES = 2;
  localparam int IDX_W = 2;
  localparam int NODE_W = 1;
  localparam int WADDR_W = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic act_wr_en = 1'b0;
  logic [IDX_W-1:0] act_wr_addr = '0;
  logic [7:0] act_wr_data = '0;
  logic start = 1'b0;
  logic busy, w_rd_en, b_rd_en, out_valid, done;
  logic [WADDR_W-1:0] w_addr;
  logic [NODE_W-1:0] b_addr, out_node;
  logic [7:0] w_data = '0;
  logic [15:0] b_data = '0;
  logic out_ready = 1'b1;
  logic [7:0] out_data;
  logic [7:0] wrom [8];
  logic [15:0] brom [2];
  int n_chk = 0;
  int n_fail = 0;

  layer_mac_sequencer #(.INPUTS(INPUTS), .NODES(NODES), .IDX_W(IDX_W),
                        .NODE_W(NODE_W), .WADDR_W(WADDR_W)) dut (
    .clk(clk), .reset(reset), .act_wr_en(act_wr_en), .act_wr_addr(act_wr_addr),
    .act_wr_data(act_wr_data), .start(start), .busy(busy), .w_rd_en(w_rd_en),
    .w_addr(w_addr), .w_data(w_data), .b_rd_en(b_rd_en), .b_addr(b_addr),
    .b_data(b_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_node(out_node), .out_data(out_data), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (w_rd_en) w_data <= wrom[w_addr];
    if (b_rd_en) b_data <= brom[b_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3);
    logic [7:0] a [4];
    a = '{a0, a1, a2, a3};
    for (int i = 0; i < 4; i++) begin
      act_wr_en = 1'b1;
      act_wr_addr = IDX_W'(i);
      act_wr_data = a[i];
      tick();
    end
    act_wr_en = 1'b0;
  endtask

  task automatic set_rom(input logic [7:0] w, input logic [15:0] b0, input logic [15:0] b1);
    for (int i = 0; i < 8; i++) wrom[i] = w;
    brom[0] = b0;
    brom[1] = b1;
  endtask

  // Full layer with out_ready high: checks both results, timing and done.
  task automatic run(input logic [7:0] e0, input logic [7:0] e1, input string tag);
    int fv, dk, nd, nv;
    fv = 0; dk = 0; nd = 0; nv = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 1);
    for (int k = 1; k <= 30; k++) begin
      if (out_valid) begin
        if (fv == 0) fv = k;
        check($sformatf("%s_node%0d", tag, nv), 32'(out_node), 32'(nv));
        check($sformatf("%s_data%0d", tag, nv), 32'(out_data), 32'(nv == 0 ? e0 : e1));
        nv++;
      end
      if (done) begin
        nd++;
        dk = k;
      end
      tick();
    end
    check({tag, "_nvalid"}, 32'(nv), 2);
    check({tag, "_ndone"}, 32'(nd), 1);
    check({tag, "_first_valid"}, 32'(fv), INPUTS + 2);
    check({tag, "_done_cycle"}, 32'(dk), NODES * (INPUTS + 2) + 1);
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    set_rom(8'd16, 16'd1024, 16'd1024);
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_node", 32'(out_node), 0);
    check("rst_wrd", 32'(w_rd_en), 0);
    check("rst_brd", 32'(b_rd_en), 0);
    check("rst_waddr", 32'(w_addr), 0);
    check("rst_baddr", 32'(b_addr), 0);
    reset = 1'b1;
    tick();

    load(8'd1, 8'd1, 8'd1, 8'd1);
    run(8'd17, 8'd17, "basic");

    load(8'd0, 8'd0, 8'd0, 8'd0);
    set_rom(8'd16, 16'd32, 16'd8160);
    run(8'd1, 8'h80, "round");

    load(8'd10, 8'd10, 8'd10, 8'd10);
    set_rom(8'hC6, 16'd0, 16'd0);
    run(8'd0, 8'd0, "relu");

    load(8'd127, 8'd127, 8'd127, 8'd127);
    set_rom(8'd127, 16'd0, 16'd0);
    run(8'd127, 8'd127, "sat");

    // Distinct weights per address and acts per index: 240 -> 4, 560 -> 9.
    load(8'd8, 8'd16, 8'd24, 8'd32);
    set_rom(8'd0, 16'd0, 16'd0);
    for (int i = 0; i < 8; i++) wrom[i] = 8'(i + 1);
    run(8'd4, 8'd9, "index");

    // Backpressure plus ignored start/write while busy.
    load(8'd1, 8'd1, 8'd1, 8'd1);
    set_rom(8'd16, 16'd1024, 16'd1024);
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20 && !out_valid; k++) tick();
    check("bp_valid_seen", 32'(out_valid), 1);
    for (int k = 0; k < 5; k++) begin
      start = (k == 1);
      act_wr_en = (k == 2);
      act_wr_addr = '0;
      act_wr_data = 8'h7f;
      check($sformatf("bp_valid%0d", k), 32'(out_valid), 1);
      check($sformatf("bp_data%0d", k), 32'(out_data), 17);
      check($sformatf("bp_node%0d", k), 32'(out_node), 0);
      check($sformatf("bp_rd%0d", k), 32'(w_rd_en | b_rd_en), 0);
      tick();
    end
    start = 1'b0;
    act_wr_en = 1'b0;
    out_ready = 1'b1;
    tick();
    for (int k = 0; k < 20 && !out_valid; k++) tick();
    check("bp_node1", 32'(out_node), 1);
    check("bp_data1", 32'(out_data), 17);
    tick();
    check("bp_done", 32'(done), 1);
    tick();
    tick();
    check("bp_no_restart", 32'(busy), 0);

    // Asynchronous reset during node 1 MAC, then restart.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    check("mid_busy_before", 32'(busy), 1);
    reset = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 0);
    check("mid_valid", 32'(out_valid), 0);
    check("mid_done", 32'(done), 0);
    check("mid_data", 32'(out_data), 0);
    check("mid_wrd", 32'(w_rd_en), 0);
    tick();
    reset = 1'b1;
    tick();
    run(8'd16, 8'd16, "cleared");
    load(8'd1, 8'd1, 8'd1, 8'd1);
    run(8'd17, 8'd17, "restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
